id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode/operand stage of the 5-stage MIPS pipeline, between the IF/ID latch and EX.
- Decodes the IF/ID instruction and drives the register-file read addresses.
- Captures the register-file read data, sign-extended immediate and control bits into the ID/EX pipeline register.
- Detects load-use hazards, issuing a stall and inserting a bubble; honours a flush request from EX (taken branch).

Parameters:
DATA_W, 32, datapath and register width
RADDR_W, 5, register address width
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  pipeline clock; ID/EX register updates on the rising edge
rst_n  in  1  asynchronous active-low reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  DATA_W  instruction word from IF/ID
if_id_pc4  in  DATA_W  PC+4 of that instruction
flush  in  1  EX resolved a taken branch/jump; kill the instruction in ID
rf_raddr1  out  RADDR_W  register-file read address 1 = instr[25:21] (rs); combinational
rf_raddr2  out  RADDR_W  register-file read address 2 = instr[20:16] (rt); combinational
rf_rdata1  in  DATA_W  register-file read data 1; valid from the falling edge of the current cycle
rf_rdata2  in  DATA_W  register-file read data 2
stall  out  1  hold PC and IF/ID this cycle; combinational
ex_valid  out  1  ID/EX holds a real instruction
ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  DATA_W each  registered operands; ex_imm = sign-extended instr[15:0]
ex_rs, ex_rt, ex_dest  out  RADDR_W each  source registers and destination register (rd for R-type, rt for lw/addi, 0 otherwise)
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each  registered control bits
ex_alu_op  out  3  0=add 1=sub 2=and 3=or 4=slt
illegal  out  1  one-cycle registered pulse on an unsupported opcode/funct
stall_count  out  CNT_W  stall cycles since reset; saturates at all-ones

Behaviour:
- Reset (async, rst_n=0): every ex_* output, illegal and stall_count go to 0 immediately. stall is combinational and reads 0 because ex_valid=0.
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
  - Control decode:
    - R-type: reg_write=1, alu_op from funct.
    - lw: reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, add.
    - sw: mem_write=1, alu_src=1, add.
    - beq: branch=1, sub.
    - addi: reg_write=1, alu_src=1, add.
- Write to $0: ex_dest=0 forces ex_reg_write=0.
- Register-file timing: the file reads on the falling edge and writes on the rising edge. The posedge capture of rf_rdata1/2 therefore already reflects any writeback done at the start of the same cycle. No WB-to-ID bypass in this block.
- Load-use hazard (combinational): hazard = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==rs | (uses_rt & ex_dest==rt)). uses_rt=1 for R-type, sw, beq only.
- stall = if_id_valid & hazard & !flush.
- Rising-edge update, priority flush > stall > normal:
  - flush=1: load bubble (ex_valid=0, all ex_* fields and controls 0). No illegal pulse.
  - stall=1: load bubble; stall_count increments (saturating). The instruction stays in IF/ID and is re-decoded next cycle. The hazard clears because ex_valid is now 0.
  - if_id_valid=0: load bubble.
  - otherwise, supported instruction: ex_valid=1; capture decode, operands and pc4.
  - otherwise, unsupported instruction: load bubble, illegal=1 for one cycle.
- A load-use stall lasts exactly one cycle. Two back-to-back lw with the dependent third instruction still gives one stall.
- Reset asserted mid-stall or mid-flush: outputs clear at once. The first edge after release behaves as normal decode.
- stall_count holds at 2^CNT_W-1 once reached.

Test Plan:
- Reset: rst_n=0 between edges -> all ex_* outputs, illegal and stall_count = 0 before the next edge; stall=0.
- addi $8,$0,5 (0x20080005) with rf_rdata1=0 -> next edge:
  - ex_valid=1, ex_dest=8, ex_imm=5, ex_alu_src=1, ex_reg_write=1, ex_alu_op=0.
  - addi $9,$0,-1 gives ex_imm=0xFFFFFFFF.
- lw $9,0($8), then add $10,$9,$11 -> stall=1 for exactly one cycle, one bubble (ex_valid=0), stall_count=1. The add then issues with ex_rs=9, ex_rt=11, ex_dest=10.
- lw $9,0($8), then addi $9,$9,1 -> stall (rs match). lw then sw $9,0($12) -> stall (rt used). lw $0 then add using $0 -> no stall.
- Hazard with flush=1 in the same cycle -> stall=0, bubble loaded, stall_count unchanged. Sub with rd=0 -> ex_valid=1, ex_reg_write=0.
- Opcode 0x3F, or R-type funct 0x08 -> ex_valid=0, illegal high for exactly one cycle. Stall counter preset near max via 300 forced stalls with CNT_W=8 -> stall_count sticks at 255.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundles the IF/ID, register-file and ID/EX signals of the decode stage.
// The slave modport is the stage itself; the master side feeds it and consumes its outputs.
interface id_ex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic               if_id_valid;
    logic [DATA_W-1:0]  if_id_instr;
    logic [DATA_W-1:0]  if_id_pc4;
    logic               flush;
    logic [RADDR_W-1:0] rf_raddr1;
    logic [RADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0]  rf_rdata1;
    logic [DATA_W-1:0]  rf_rdata2;
    logic               stall;
    logic               ex_valid;
    logic [DATA_W-1:0]  ex_pc4;
    logic [DATA_W-1:0]  ex_rdata1;
    logic [DATA_W-1:0]  ex_rdata2;
    logic [DATA_W-1:0]  ex_imm;
    logic [RADDR_W-1:0] ex_rs;
    logic [RADDR_W-1:0] ex_rt;
    logic [RADDR_W-1:0] ex_dest;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_mem_to_reg;
    logic               ex_alu_src;
    logic               ex_branch;
    logic [2:0]         ex_alu_op;
    logic               illegal;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output if_id_valid, if_id_instr, if_id_pc4, flush, rf_rdata1, rf_rdata2,
        input  rf_raddr1, rf_raddr2, stall, ex_valid, ex_pc4, ex_rdata1, ex_rdata2, ex_imm,
               ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op, illegal, stall_count
    );

    modport slave (
        input  if_id_valid, if_id_instr, if_id_pc4, flush, rf_rdata1, rf_rdata2,
        output rf_raddr1, rf_raddr2, stall, ex_valid, ex_pc4, ex_rdata1, ex_rdata2, ex_imm,
               ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op, illegal, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS decode/operand stage: decodes IF/ID, reads the register file, detects
// load-use hazards and loads the ID/EX pipeline register (flush > stall > normal).
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc4;
        logic [DATA_W-1:0]  rdata1;
        logic [DATA_W-1:0]  rdata2;
        logic [DATA_W-1:0]  imm;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] dest;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               branch;
        alu_op_e            alu_op;
    } ex_reg_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [5:0]         w_opcode;
    logic [5:0]         w_funct;
    logic [RADDR_W-1:0] w_rs;
    logic [RADDR_W-1:0] w_rt;
    logic [RADDR_W-1:0] w_rd;
    logic               w_unused_shamt;
    ex_reg_t            w_dec;
    logic               w_supported;
    logic               w_uses_rt;
    logic               w_hazard;
    logic               w_stall;
    ex_reg_t            r_ex;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_stall_count;

    assign w_opcode       = bus.if_id_instr[31:26];
    assign w_funct        = bus.if_id_instr[5:0];
    assign w_rs           = bus.if_id_instr[25:21];
    assign w_rt           = bus.if_id_instr[20:16];
    assign w_rd           = bus.if_id_instr[15:11];
    assign w_unused_shamt = ^bus.if_id_instr[10:6];

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        w_dec        = '0;
        w_supported  = 1'b0;
        w_uses_rt    = 1'b0;
        w_dec.valid  = 1'b1;
        w_dec.pc4    = bus.if_id_pc4;
        w_dec.rdata1 = bus.rf_rdata1;
        w_dec.rdata2 = bus.rf_rdata2;
        w_dec.imm    = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
        w_dec.rs     = w_rs;
        w_dec.rt     = w_rt;
        w_dec.alu_op = ALU_ADD;
        case (w_opcode)
            OP_RTYPE: begin
                w_uses_rt       = 1'b1;
                w_dec.dest      = w_rd;
                w_dec.reg_write = 1'b1;
                w_supported     = 1'b1;
                case (w_funct)
                    FN_ADD:  w_dec.alu_op = ALU_ADD;
                    FN_SUB:  w_dec.alu_op = ALU_SUB;
                    FN_AND:  w_dec.alu_op = ALU_AND;
                    FN_OR:   w_dec.alu_op = ALU_OR;
                    FN_SLT:  w_dec.alu_op = ALU_SLT;
                    default: w_supported  = 1'b0;
                endcase
            end
            OP_LW: begin
                w_dec.dest       = w_rt;
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_supported      = 1'b1;
            end
            OP_SW: begin
                w_uses_rt       = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_supported     = 1'b1;
            end
            OP_BEQ: begin
                w_uses_rt    = 1'b1;
                w_dec.branch = 1'b1;
                w_dec.alu_op = ALU_SUB;
                w_supported  = 1'b1;
            end
            OP_ADDI: begin
                w_dec.dest      = w_rt;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_supported     = 1'b1;
            end
            default: w_supported = 1'b0;
        endcase
        // $0 is hard-wired, so a write to it is dropped here rather than in WB.
        if (w_dec.dest == '0) w_dec.reg_write = 1'b0;
    end

    assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.dest != '0) &&
                      ((r_ex.dest == w_rs) || (w_uses_rt && (r_ex.dest == w_rt)));
    assign w_stall  = bus.if_id_valid && w_hazard && !bus.flush;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex          <= '0;
            r_illegal     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_illegal <= 1'b0;
            if (bus.flush || w_stall || !bus.if_id_valid) begin
                r_ex <= '0;
            end else if (w_supported) begin
                r_ex <= w_dec;
            end else begin
                r_ex      <= '0;
                r_illegal <= 1'b1;
            end
            if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus.rf_raddr1     = w_rs;
    assign bus.rf_raddr2     = w_rt;
    assign bus.stall         = w_stall;
    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_pc4        = r_ex.pc4;
    assign bus.ex_rdata1     = r_ex.rdata1;
    assign bus.ex_rdata2     = r_ex.rdata2;
    assign bus.ex_imm        = r_ex.imm;
    assign bus.ex_rs         = r_ex.rs;
    assign bus.ex_rt         = r_ex.rt;
    assign bus.ex_dest       = r_ex.dest;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
    assign bus.ex_alu_src    = r_ex.alu_src;
    assign bus.ex_branch     = r_ex.branch;
    assign bus.ex_alu_op     = r_ex.alu_op;
    assign bus.illegal       = r_illegal;
    assign bus.stall_count   = r_stall_count;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push the expected
// ID/EX contents; a monitor pops and compares one entry per clock edge.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) u_if ();
    id_ex_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if)
    );

    typedef struct packed {
        logic          valid;
        logic [31:0]   pc4;
        logic [31:0]   rdata1;
        logic [31:0]   rdata2;
        logic [31:0]   imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dest;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          m2r;
        logic          as;
        logic          br;
        logic [2:0]    aop;
        logic          ill;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t bubble(input logic ill);
        exp_t e = '0;
        e.ill = ill;
        e.cnt = exp_cnt;
        return e;
    endfunction

    function automatic exp_t op(input logic [31:0] pc4, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dest, input logic rw, input logic mr, input logic mw,
                                input logic m2r, input logic as, input logic br, input logic [2:0] aop);
        exp_t e = '0;
        e.valid = 1'b1;  e.pc4 = pc4;  e.rdata1 = r1;  e.rdata2 = r2;  e.imm = imm;
        e.rs = rs;  e.rt = rt;  e.dest = dest;
        e.rw = rw;  e.mr = mr;  e.mw = mw;  e.m2r = m2r;  e.as = as;  e.br = br;  e.aop = aop;
        e.cnt = exp_cnt;
        return e;
    endfunction

    task automatic bump();
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [31:0] r1, input logic [31:0] r2, input logic fl,
                         input logic exp_stall, input exp_t e);
        @(negedge clk);
        u_if.if_id_valid = v;
        u_if.if_id_instr = ins;
        u_if.if_id_pc4   = pc4;
        u_if.rf_rdata1   = r1;
        u_if.rf_rdata2   = r2;
        u_if.flush       = fl;
        #1;
        check("stall", 256'(u_if.stall), 256'(exp_stall));
        sb_q.push_back(e);
    endtask

    // Monitor: the ID/EX register is compared 1 time unit after every rising edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = '0;
                a.valid = u_if.ex_valid;      a.pc4 = u_if.ex_pc4;
                a.rdata1 = u_if.ex_rdata1;    a.rdata2 = u_if.ex_rdata2;
                a.imm = u_if.ex_imm;          a.rs = u_if.ex_rs;
                a.rt = u_if.ex_rt;            a.dest = u_if.ex_dest;
                a.rw = u_if.ex_reg_write;     a.mr = u_if.ex_mem_read;
                a.mw = u_if.ex_mem_write;     a.m2r = u_if.ex_mem_to_reg;
                a.as = u_if.ex_alu_src;       a.br = u_if.ex_branch;
                a.aop = u_if.ex_alu_op;       a.ill = u_if.illegal;
                a.cnt = u_if.stall_count;
                check("ex_regs", 256'(a), 256'(e));
            end
        end
    end

    initial begin
        u_if.if_id_valid = 1'b0;
        u_if.if_id_instr = '0;
        u_if.if_id_pc4   = '0;
        u_if.rf_rdata1   = '0;
        u_if.rf_rdata2   = '0;
        u_if.flush       = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_ex_valid", 256'(u_if.ex_valid), 256'(0));
        check("reset_illegal", 256'(u_if.illegal), 256'(0));
        check("reset_stall_count", 256'(u_if.stall_count), 256'(0));
        check("reset_stall", 256'(u_if.stall), 256'(0));
        check("reset_ex_imm", 256'(u_if.ex_imm), 256'(0));
        @(negedge clk) rst_n = 1'b1;

        // addi $8,$0,5 and addi $9,$0,-1
        drive(1, 32'h20080005, 32'h104, 32'h0, 32'h77, 0, 0, op(32'h104, 32'h0, 32'h77, 32'h5, 0, 8, 8, 1, 0, 0, 0, 1, 0, 0));
        check("rf_raddr1", 256'(u_if.rf_raddr1), 256'(0));
        check("rf_raddr2", 256'(u_if.rf_raddr2), 256'(8));
        drive(1, 32'h2009FFFF, 32'h108, 32'h0, 32'h55, 0, 0, op(32'h108, 32'h0, 32'h55, 32'hFFFFFFFF, 0, 9, 9, 1, 0, 0, 0, 1, 0, 0));

        // lw $9,0($8) ; add $10,$9,$11 -> one stall then issue
        drive(1, 32'h8D090000, 32'h10C, 32'h40, 32'h99, 0, 0, op(32'h10C, 32'h40, 32'h99, 32'h0, 8, 9, 9, 1, 1, 0, 1, 1, 0, 0));
        bump();
        drive(1, 32'h012B5020, 32'h110, 32'h11, 32'h22, 0, 1, bubble(0));
        drive(1, 32'h012B5020, 32'h110, 32'h33, 32'h44, 0, 0, op(32'h110, 32'h33, 32'h44, 32'h5020, 9, 11, 10, 1, 0, 0, 0, 0, 0, 0));

        // lw ; addi $9,$9,1 -> rs match
        drive(1, 32'h8D090000, 32'h114, 32'h40, 32'h99, 0, 0, op(32'h114, 32'h40, 32'h99, 32'h0, 8, 9, 9, 1, 1, 0, 1, 1, 0, 0));
        bump();
        drive(1, 32'h21290001, 32'h118, 32'h1, 32'h2, 0, 1, bubble(0));
        drive(1, 32'h21290001, 32'h118, 32'h7, 32'h66, 0, 0, op(32'h118, 32'h7, 32'h66, 32'h1, 9, 9, 9, 1, 0, 0, 0, 1, 0, 0));

        // lw ; sw $9,0($12) -> rt match
        drive(1, 32'h8D090000, 32'h11C, 32'h40, 32'h99, 0, 0, op(32'h11C, 32'h40, 32'h99, 32'h0, 8, 9, 9, 1, 1, 0, 1, 1, 0, 0));
        bump();
        drive(1, 32'hAD890000, 32'h120, 32'h1, 32'h2, 0, 1, bubble(0));
        drive(1, 32'hAD890000, 32'h120, 32'h500, 32'h600, 0, 0, op(32'h120, 32'h500, 32'h600, 32'h0, 12, 9, 0, 0, 0, 1, 0, 1, 0, 0));

        // lw $0 ; add $10,$0,$0 -> no stall
        drive(1, 32'h8D000000, 32'h124, 32'h40, 32'h99, 0, 0, op(32'h124, 32'h40, 32'h99, 32'h0, 8, 0, 0, 0, 1, 0, 1, 1, 0, 0));
        drive(1, 32'h00005020, 32'h128, 32'h0, 32'h0, 0, 0, op(32'h128, 32'h0, 32'h0, 32'h5020, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0));

        // hazard with flush -> no stall, bubble, count unchanged
        drive(1, 32'h8D090000, 32'h12C, 32'h40, 32'h99, 0, 0, op(32'h12C, 32'h40, 32'h99, 32'h0, 8, 9, 9, 1, 1, 0, 1, 1, 0, 0));
        drive(1, 32'h012B5020, 32'h130, 32'h11, 32'h22, 1, 0, bubble(0));

        // sub $0 (write dropped), beq, and, or, slt
        drive(1, 32'h01090022, 32'h130, 32'h8, 32'h9, 0, 0, op(32'h130, 32'h8, 32'h9, 32'h22, 8, 9, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(1, 32'h11090004, 32'h134, 32'h8, 32'h9, 0, 0, op(32'h134, 32'h8, 32'h9, 32'h4, 8, 9, 0, 0, 0, 0, 0, 0, 1, 1));
        drive(1, 32'h01095824, 32'h138, 32'hF0, 32'h3C, 0, 0, op(32'h138, 32'hF0, 32'h3C, 32'h5824, 8, 9, 11, 1, 0, 0, 0, 0, 0, 2));
        drive(1, 32'h01096025, 32'h13C, 32'hF0, 32'h3C, 0, 0, op(32'h13C, 32'hF0, 32'h3C, 32'h6025, 8, 9, 12, 1, 0, 0, 0, 0, 0, 3));
        drive(1, 32'h0109682A, 32'h140, 32'hF0, 32'h3C, 0, 0, op(32'h140, 32'hF0, 32'h3C, 32'h682A, 8, 9, 13, 1, 0, 0, 0, 0, 0, 4));

        // illegal opcode 0x3F, idle slot, R-type funct 0x08, then a legal addi
        drive(1, 32'hFC000000, 32'h144, 32'h1, 32'h2, 0, 0, bubble(1));
        drive(0, 32'h00000000, 32'h148, 32'h1, 32'h2, 0, 0, bubble(0));
        drive(1, 32'h01000008, 32'h14C, 32'h1, 32'h2, 0, 0, bubble(1));
        drive(1, 32'h20080005, 32'h150, 32'h0, 32'h77, 0, 0, op(32'h150, 32'h0, 32'h77, 32'h5, 0, 8, 8, 1, 0, 0, 0, 1, 0, 0));

        // 300 forced stalls: stall_count must stick at 255
        for (int i = 0; i < 300; i++) begin
            drive(1, 32'h8D090000, 32'h200, 32'h40, 32'h99, 0, 0, op(32'h200, 32'h40, 32'h99, 32'h0, 8, 9, 9, 1, 1, 0, 1, 1, 0, 0));
            bump();
            drive(1, 32'h012B5020, 32'h204, 32'h11, 32'h22, 0, 1, bubble(0));
        end
        @(negedge clk);
        check("stall_count_sat", 256'(u_if.stall_count), 256'(255));

        // reset asserted while a stall is pending
        drive(1, 32'h8D090000, 32'h300, 32'h40, 32'h99, 0, 0, op(32'h300, 32'h40, 32'h99, 32'h0, 8, 9, 9, 1, 1, 0, 1, 1, 0, 0));
        @(negedge clk);
        u_if.if_id_instr = 32'h012B5020;
        u_if.if_id_pc4   = 32'h304;
        u_if.rf_rdata1   = 32'hAA;
        u_if.rf_rdata2   = 32'hBB;
        #1 check("stall_before_reset", 256'(u_if.stall), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midstall_reset_stall", 256'(u_if.stall), 256'(0));
        check("midstall_reset_ex_valid", 256'(u_if.ex_valid), 256'(0));
        check("midstall_reset_count", 256'(u_if.stall_count), 256'(0));
        exp_cnt = 8'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        sb_q.push_back(op(32'h304, 32'hAA, 32'hBB, 32'h5020, 9, 11, 10, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) check("scoreboard_drain", 256'(sb_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
